wrr_arbiter: RTL
================

Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter; successor to the fixed 4-requester round-robin arbiter.
- N requesters share one resource. Each winner may keep the grant for up to its programmed weight consecutive cycles, or longer while it asserts lock.
- Registered one-hot grant plus encoded index and valid, for driving a downstream mux directly.
- Sits in front of shared buses/memories.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- WEIGHT_W, 4, width of each per-requester weight field.
- IDX_W, $clog2(N_REQ), width of grant index (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_i  input  N_REQ  per-requester request, level.
- weight_i  input  N_REQ*WEIGHT_W  packed weights; requester k at bits [k*WEIGHT_W +: WEIGHT_W].
- lock_i  input  1  current owner requests extension beyond its weight.
- gnt_o  output  N_REQ  registered one-hot grant.
- gnt_id_o  output  IDX_W  index of granted requester.
- gnt_valid_o  output  1  any grant active (= |gnt_o).

Behaviour:
- Reset (sync, active-high, sampled at posedge): gnt_o=0, gnt_id_o=0, gnt_valid_o=0, ptr_q=0, cnt_q=0. Reset overrides all other inputs. Reset mid-burst discards credits and lock.
- State: IDLE (gnt_valid_o=0) or GRANT. Internal ptr_q is the highest-priority index; cnt_q holds remaining credits.
- Latency: one cycle. Grant in cycle t+1 reflects req_i/lock_i/weight_i sampled at the edge ending cycle t.
- HOLD rule, evaluated at each edge while in GRANT:
  - Applies if req_i[owner]=1 and (cnt_q>1 or lock_i=1).
  - Grant unchanged.
  - cnt_q decrements, saturating at 1 while lock_i is high.
- ARBITRATE rule: applies otherwise, i.e. in IDLE, owner dropped req, or credits exhausted without lock.
  - Search req_i circularly starting at ptr_q; the first set bit wins.
  - Winner w: gnt_o=1<<w, gnt_id_o=w, cnt_q=max(weight_i[w],1), ptr_q=(w+1) mod N_REQ.
  - No request: go to IDLE, gnt_o=0, gnt_id_o holds its last value, ptr_q unchanged.
- Owner with exhausted credits that is still requesting is eligible only after all others (ptr_q is already w+1). If it is the sole requester it is re-granted with no bubble cycle.
- Weight is sampled only when a grant is issued; mid-burst weight changes take effect at the next grant. Weight 0 behaves as 1.
- lock_i is ignored in IDLE and ignored when the owner's req is low.
- Max weight 2^WEIGHT_W−1 cycles; cnt_q never wraps.
- Invariants: gnt_o is always one-hot or zero, and gnt_o[k]=1 only if req_i[k] was 1 at the previous edge.
- ptr_q wraps from N_REQ−1 to 0. N_REQ need not be a power of two; indices ≥N_REQ are never produced.

Decomposition:
- Package wrr_arb_pkg: default constants (DEF_N_REQ=4, DEF_WEIGHT_W=4), state enum arb_state_e {ARB_IDLE, ARB_GRANT}, and function max1() for weight clamping.
- One combinational sub-module rr_pick #(N): inputs req vector and start pointer; outputs found flag and winner index. Implemented as a double-width masked priority encode. Reused by later arbiters.
- wrr_arbiter holds state, pointer and credit registers.

Test Plan:
- Reset: reset=1 for 2 cycles with req_i=4'hF → gnt_o=0, gnt_valid_o=0 throughout. First edge after release → gnt_o=4'h1, gnt_id_o=0.
- Equal weights all 1, req_i=4'hF held → gnt_o sequence 1,2,4,8,1,2… each for one cycle, no idle gaps.
- Weights w0=3, w1=1, w2=2, w3=1, req_i=4'hF → grant order 0,0,0,1,2,2,3,0,0,0… (gnt_id_o).
- Early drop: w0=4, req0 deasserted after 2 grant cycles, req_i=4'hB otherwise → gnt_o 4'h1 for exactly 2 cycles then 4'h2; ptr_q=2 next.
- Lock and reset: w1=1, requester 1 owns grant, lock_i=1 for 5 cycles, req_i=4'h6 → gnt_o=4'h2 for 6 cycles then 4'h4. Repeat, asserting reset in cycle 3 of the lock → gnt_o=0 next cycle, then gnt_o=4'h2 after release (ptr reset to 0, req0 absent).
- Sole requester and weight 0: req_i=4'h4, w2=0 → gnt_o=4'h4 continuously, no bubbles. Then 32 cycles of random req_i/weights with checker asserting the one-hot and req-before-grant invariants and per-requester starvation bound Σ max(w,1).

Source files
------------

// File: rtl/wrr_arb_pkg.sv
// rtl/wrr_arb_pkg.sv - shared constants, state type and weight clamp for the arbiters
package wrr_arb_pkg;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WEIGHT_W = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // A zero weight still earns one grant cycle.
    function automatic int max1(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - circular first-set-bit search of a request vector from a start index
module rr_pick
    import wrr_arb_pkg::*;
#(
    parameter  int N     = DEF_N_REQ,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [IDX_W:0] pos;

    // Lower copy is masked below start; the upper copy supplies the wrap-around.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            dbl[i]     = req[i] && (IDX_W'(i) >= start);
            dbl[N + i] = req[i];
        end
    end

    always_comb begin
        pos = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i]) begin
                pos = (IDX_W+1)'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = (pos >= (IDX_W+1)'(N)) ? IDX_W'(pos - (IDX_W+1)'(N)) : IDX_W'(pos);

endmodule

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with lock extension and registered grant
module wrr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter  int N_REQ    = DEF_N_REQ,
    parameter  int WEIGHT_W = DEF_WEIGHT_W,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*WEIGHT_W-1:0] weight_i,
    input  logic                      lock_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [IDX_W-1:0]          gnt_id_o,
    output logic                      gnt_valid_o
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    id_q, id_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                hold;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_i),
        .start (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hold = (state_q == ARB_GRANT) && req_i[id_q] &&
                  ((cnt_q > WEIGHT_W'(1)) || lock_i);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        if (hold) begin
            // Under lock the credit count parks at 1 instead of wrapping.
            if (cnt_q > WEIGHT_W'(1)) begin
                cnt_d = cnt_q - WEIGHT_W'(1);
            end
        end else if (pick_found) begin
            state_d         = ARB_GRANT;
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            id_d            = pick_idx;
            cnt_d           = WEIGHT_W'(max1(int'(weight_i[pick_idx*WEIGHT_W +: WEIGHT_W])));
            ptr_d           = (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
        end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = id_q;
    assign gnt_valid_o = |gnt_q;

endmodule
